datapath_wall: RTL
==================

# datapath_wall

Wall datapath answering the wall controller's 5-bit state code. It holds the wall position and gap and moves the wall one column left per move command. It plots the wall's top and bottom segments one pixel per clock toward the VGA adapter, erases the vacated column, and raises `touched` when the player pixel overlaps a solid wall pixel. It signals command completion with `done`; the controller holds its code until it sees `done`.

## Interface
- `SCREEN_W`, 160, screen width in pixels
- `SCREEN_H`, 120, screen height in pixels
- `WALL_W`, 4, wall width in columns
- `GAP_H`, 32, gap height in rows
- `START_X`, 156, wall x (left column) after ready/wrap
- `WALL_COLOUR`, 3'b010, draw colour (erase colour is 3'b000)

Ports:
- `clk` in 1: system clock, all logic on rising edge
- `resetn` in 1: asynchronous, active-low reset
- `state_in` in 5: controller code. READY=5, MOVE=6, STOP=7, DRAW=8, DEL=9, UPDATE=10, DEL_B=12, DRAW_B=13
- `gap_y` in 7: requested gap top row, sampled on READY and on wrap
- `player_x` in 8 / `player_y` in 7: player pixel position
- `x_out` out 8 / `y_out` out 7 / `colour_out` out 3: pixel to plot
- `plot` out 1: pixel write enable
- `done` out 1: one-cycle pulse, command complete
- `touched` out 1: player overlaps the wall
- `wall_x` out 8: current wall left column

## Operation
- **Command start**
  - A command starts on the first clock where `state_in` differs from register `last_code`.
  - `last_code` resets to 5'b11111, so the code present after reset starts a command.
  - While a sweep is active, `state_in` changes are ignored.
- **Gap register**
  - `gap_top` = min(`gap_y`, `SCREEN_H`-`GAP_H`).
  - `old_gap` holds the previous `gap_top` for erasing after a wrap.
- **Segment rows**
  - Top segment: rows 0..`gap_top`-1.
  - Bottom segment: rows `gap_top`+`GAP_H`..`SCREEN_H`-1.
  - A segment may be empty.
- **Command actions**
  - READY: `wall_x`=`START_X`, load `gap_top`, clear `wrap_pending`, then done.
  - MOVE with `wall_x`>0: `wall_x`-=1, then done.
  - MOVE with `wall_x`=0: `wall_x`=`START_X`, `old_gap`=`gap_top`, load new `gap_top`, set `wrap_pending`, then done.
  - STOP, UPDATE: done only.
  - DRAW / DRAW_B: sweep the top / bottom segment.
    - Columns `wall_x`..`wall_x`+`WALL_W`-1.
    - Colour `WALL_COLOUR`.
  - DEL / DEL_B: erase the top / bottom segment.
    - If `wrap_pending`: columns 0..`WALL_W`-1, rows from `old_gap`.
    - Otherwise: the single column `wall_x`+`WALL_W` with rows from `gap_top`. Skipped (zero pixels) if that column is ≥`SCREEN_W`.
    - Colour 3'b000.
    - `wrap_pending` clears when DEL_B completes.
  - Any other code: no action, no done.
- **Sweep order**
  - Row-major: y outer, ascending; x inner, ascending.
  - One pixel per clock with `plot`=1.
- **touched** (registered every clock, independent of commands)
  - Set when `player_x` is in [`wall_x`, `wall_x`+`WALL_W`-1] and `player_y` is outside [`gap_top`, `gap_top`+`GAP_H`-1].
- **Widths**
  - Column arithmetic in 9 bits to avoid overflow at `wall_x`+`WALL_W`.
  - Row arithmetic in 8 bits.

## Timing
- **Reset**
  - Outputs: `x_out`=0, `y_out`=0, `colour_out`=0, `plot`=0, `done`=0, `touched`=0, `wall_x`=`START_X`.
  - Internal: `gap_top`=0, `old_gap`=0, `wrap_pending`=0, sweep idle.
- Reset asserted mid-sweep: `plot` drops immediately (asynchronous), the sweep is abandoned, and no `done` is issued.
- All outputs are registered.
- Command seen at edge N:
  - First pixel valid in the cycle after N; pixel k valid k cycles later.
  - P-pixel sweep: `done` is high in the cycle after the last pixel (N+1+P).
  - P=0, and non-sweep commands: `done` in cycle N+1.
- `plot` and `done` are never high in the same cycle.
- `wall_x` / `gap_top` updates are visible in the cycle after N.

## Test plan
- Reset, then READY with `gap_y`=40:
  - `wall_x`=156, `gap_top`=40.
  - `done` one cycle after the code is seen; `plot` stays 0.
- DRAW after the READY above:
  - 160 pixels, first (156,0), last (159,39), colour 3'b010.
  - `done` next cycle.
- DRAW_B after the READY above:
  - 192 pixels, rows 72..119, first (156,72), last (159,119).
- MOVE from `wall_x`=156, then DEL:
  - `wall_x`=155.
  - Erases column 159 rows 0..39 (40 pixels, colour 0).
- Wrap: `wall_x`=0, MOVE with `gap_y`=100:
  - `wall_x`=156, `gap_top`=88 (clamped).
  - DEL erases x 0..3, rows 0..39 (160 pixels).
  - DEL_B erases x 0..3, rows 72..119.
  - A following DEL erases column 160 → zero pixels, immediate `done`.
- `wall_x`=156, `gap_top`=40:
  - Player (157,20) → `touched`=1.
  - Player (157,50) → `touched`=0.
  - Reset asserted during DRAW pixel 10 → `plot`=0 at once, no `done`, `wall_x`=156.

Source files
------------

// File: rtl/datapath_wall.sv
// Wall datapath: holds wall position and gap, moves the wall, and streams wall
// draw/erase pixels one per clock while flagging player-vs-wall contact.
module datapath_wall #(
  parameter int           SCREEN_W    = 160,
  parameter int           SCREEN_H    = 120,
  parameter int           WALL_W      = 4,
  parameter int           GAP_H       = 32,
  parameter int           START_X     = 156,
  parameter logic [2:0]   WALL_COLOUR = 3'b010
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [4:0] state_in,
  input  logic [6:0] gap_y,
  input  logic [7:0] player_x,
  input  logic [6:0] player_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       done,
  output logic       touched,
  output logic [7:0] wall_x
);

  localparam logic [4:0] C_READY  = 5'd5;
  localparam logic [4:0] C_MOVE   = 5'd6;
  localparam logic [4:0] C_STOP   = 5'd7;
  localparam logic [4:0] C_DRAW   = 5'd8;
  localparam logic [4:0] C_DEL    = 5'd9;
  localparam logic [4:0] C_UPDATE = 5'd10;
  localparam logic [4:0] C_DEL_B  = 5'd12;
  localparam logic [4:0] C_DRAW_B = 5'd13;

  localparam logic [6:0] GAP_MAX = 7'(SCREEN_H - GAP_H);

  logic [4:0] last_code;
  logic [6:0] gap_top;
  logic [6:0] old_gap;
  logic       wrap_pending;
  logic       busy;
  logic       sweep_delb;
  logic [8:0] cur_x;
  logic [8:0] sx_start;
  logic [8:0] sx_end;
  logic [7:0] cur_y;
  logic [7:0] sy_end;

  logic       start;
  logic [8:0] wall_x9;
  logic [6:0] gap_clamped;
  logic       set_sweep;
  logic       set_bottom;
  logic       set_empty;
  logic [2:0] set_colour;
  logic [8:0] set_x_start;
  logic [8:0] set_x_end;
  logic [7:0] gap_sel;
  logic [7:0] set_y_start;
  logic [7:0] set_y_end;
  logic [8:0] px9;
  logic [7:0] py8;
  logic [7:0] gap8;
  logic       hit_x;
  logic       hit_y;

  assign start = !busy && (state_in != last_code);

  // Sweep setup for the code currently presented; only used when a command starts.
  always_comb begin
    wall_x9     = {1'b0, wall_x};
    gap_clamped = (gap_y > GAP_MAX) ? GAP_MAX : gap_y;
    set_sweep   = 1'b0;
    set_bottom  = 1'b0;
    set_colour  = WALL_COLOUR;
    set_x_start = wall_x9;
    set_x_end   = wall_x9 + 9'(WALL_W);
    gap_sel     = {1'b0, gap_top};
    case (state_in)
      C_DRAW:   set_sweep = 1'b1;
      C_DRAW_B: begin
        set_sweep  = 1'b1;
        set_bottom = 1'b1;
      end
      C_DEL, C_DEL_B: begin
        set_sweep  = 1'b1;
        set_bottom = (state_in == C_DEL_B);
        set_colour = 3'b000;
        if (wrap_pending) begin
          set_x_start = 9'd0;
          set_x_end   = 9'(WALL_W);
          gap_sel     = {1'b0, old_gap};
        end else begin
          set_x_start = wall_x9 + 9'(WALL_W);
          set_x_end   = wall_x9 + 9'(WALL_W) + 9'd1;
        end
      end
      default: ;
    endcase
    set_y_start = set_bottom ? (gap_sel + 8'(GAP_H)) : 8'd0;
    set_y_end   = set_bottom ? 8'(SCREEN_H) : gap_sel;
    set_empty   = (set_y_start >= set_y_end) || (set_x_start >= 9'(SCREEN_W));
  end

  always_comb begin
    px9   = {1'b0, player_x};
    py8   = {1'b0, player_y};
    gap8  = {1'b0, gap_top};
    hit_x = (px9 >= wall_x9) && (px9 < wall_x9 + 9'(WALL_W));
    hit_y = (py8 < gap8) || (py8 >= gap8 + 8'(GAP_H));
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_code    <= 5'b11111;
      gap_top      <= '0;
      old_gap      <= '0;
      wrap_pending <= 1'b0;
      busy         <= 1'b0;
      sweep_delb   <= 1'b0;
      cur_x        <= '0;
      cur_y        <= '0;
      sx_start     <= '0;
      sx_end       <= '0;
      sy_end       <= '0;
      x_out        <= '0;
      y_out        <= '0;
      colour_out   <= '0;
      plot         <= 1'b0;
      done         <= 1'b0;
      touched      <= 1'b0;
      wall_x       <= 8'(START_X);
    end else begin
      done    <= 1'b0;
      touched <= hit_x && hit_y;
      if (busy) begin
        // Row-major walk: x inner, y outer; done follows the final pixel.
        if (cur_x + 9'd1 < sx_end) begin
          cur_x <= cur_x + 9'd1;
          x_out <= 8'(cur_x + 9'd1);
        end else if (cur_y + 8'd1 < sy_end) begin
          cur_x <= sx_start;
          cur_y <= cur_y + 8'd1;
          x_out <= sx_start[7:0];
          y_out <= 7'(cur_y + 8'd1);
        end else begin
          busy <= 1'b0;
          plot <= 1'b0;
          done <= 1'b1;
          if (sweep_delb) wrap_pending <= 1'b0;
        end
      end else if (start) begin
        last_code <= state_in;
        case (state_in)
          C_READY: begin
            wall_x       <= 8'(START_X);
            gap_top      <= gap_clamped;
            wrap_pending <= 1'b0;
            done         <= 1'b1;
          end
          C_MOVE: begin
            if (wall_x != 8'd0) begin
              wall_x <= wall_x - 8'd1;
            end else begin
              wall_x       <= 8'(START_X);
              old_gap      <= gap_top;
              gap_top      <= gap_clamped;
              wrap_pending <= 1'b1;
            end
            done <= 1'b1;
          end
          C_STOP, C_UPDATE: done <= 1'b1;
          default: begin
            if (set_sweep) begin
              if (set_empty) begin
                done <= 1'b1;
                if (state_in == C_DEL_B) wrap_pending <= 1'b0;
              end else begin
                busy       <= 1'b1;
                plot       <= 1'b1;
                colour_out <= set_colour;
                sweep_delb <= (state_in == C_DEL_B);
                cur_x      <= set_x_start;
                cur_y      <= set_y_start;
                sx_start   <= set_x_start;
                sx_end     <= set_x_end;
                sy_end     <= set_y_end;
                x_out      <= set_x_start[7:0];
                y_out      <= set_y_start[6:0];
              end
            end
          end
        endcase
      end
    end
  end

endmodule
